instruction_fifo: RTL and testbench
===================================

INSTRUCTION_FIFO -- requirements
Module: instruction_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of two, >=4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-004 SHALL have port fifo_flush  input  1  discard all entries (redirect/exception).
REQ-005 SHALL have ports write_en1, write_en2  input  1 each  push slot 1 / slot 2 (fetch side).
REQ-006 SHALL have ports write_inst1, write_inst2, write_addr1, write_addr2  input  32 each  instruction words and their PCs.
REQ-007 SHALL have ports read_en1, read_en2  input  1 each  pop master / slave (issue side).
REQ-008 SHALL have ports read_inst1, read_inst2, read_addr1, read_addr2  output  32 each  head and head+1 entries.
REQ-009 SHALL have ports empty, almost_empty, almost_full, full  output  1 each  occupancy flags.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port overflow  output  1  sticky lost-write flag (see Configuration).

Function
REQ-012 SHALL keep head pointer, tail pointer (log2 DEPTH bits, natural wrap-around) and count register.
REQ-013 SHALL treat write_en2 as valid only with write_en1; write_en2 alone writes nothing.
REQ-014 SHALL accept a write request of N entries (N=1 or 2) only when DEPTH-count >= N at the start of the cycle; otherwise no entry is written.
REQ-015 SHALL store slot 1 at tail and slot 2 at tail+1 (modulo DEPTH), advancing tail by N.
REQ-016 SHALL treat read_en2 as valid only with read_en1; pops = min(requested, count) at start of cycle; reads on empty do nothing.
REQ-017 SHALL advance head by pops; count_next = count + accepted writes - pops.
REQ-018 SHALL evaluate write acceptance on pre-cycle count; same-cycle pops do not free space for same-cycle writes.
REQ-019 SHALL present read_inst1/read_addr1 combinationally from head and read_inst2/read_addr2 from head+1; zero when the entry is not occupied (count<1 / count<2).
REQ-020 SHALL make written data visible on read ports the cycle after the write edge; no write-to-read bypass.
REQ-021 SHALL drive empty = (count==0), almost_empty = (count==1), almost_full = (count>=DEPTH-2), full = (count==DEPTH), all from registered count.
REQ-022 SHALL on fifo_flush set head, tail, count to 0 at the next edge, overriding same-cycle writes and reads.

Reset
REQ-023 SHALL on rst asynchronously clear head, tail, count and overflow; outputs then empty=1, almost_empty=0, almost_full=0, full=0, count=0, all read data 0.
REQ-024 SHALL not require storage array reset; reset mid-operation discards all entries identically to flush.

Configuration
REQ-025 SHALL use macro INST_FIFO_OVERFLOW_EN.
REQ-026 SHALL with INST_FIFO_OVERFLOW_EN defined set overflow to 1 at the edge after any rejected write request (REQ-014) and hold it until rst or fifo_flush.
REQ-027 SHALL without INST_FIFO_OVERFLOW_EN tie overflow to 0 and instantiate no overflow logic.

Verification (DEPTH=16)
REQ-028 SHALL cover: reset, push pair (0x24020001@0xBFC00000, 0x24030002@0xBFC00004) -> next cycle count=2, read_inst1=0x24020001, read_inst2=0x24030002, empty=0.
REQ-029 SHALL cover: count=1, read_en1=read_en2=1 -> one pop, count=0, empty=1, read_inst2 stayed 0 throughout.
REQ-030 SHALL cover: count=15, dual write with dual read -> write rejected, count=13, overflow=1 (macro on) / 0 (macro off).
REQ-031 SHALL cover: 40 single pushes interleaved with pops -> pointer wrap, FIFO order preserved, PCs read back in write order.
REQ-032 SHALL cover: count=9, fifo_flush with write_en1=1 same cycle -> count=0, empty=1, overflow cleared.
REQ-033 SHALL cover: rst asserted mid-cycle at count=7 -> outputs reset without clock edge, count=0 immediately.

Source files
------------

// File: rtl/instruction_fifo.sv
// Dual-issue instruction FIFO: up to two pushes and two pops per cycle.
// Define INST_FIFO_OVERFLOW_EN to enable the sticky overflow (lost-write) flag.
module instruction_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_flush,
    input  logic                     write_en1,
    input  logic                     write_en2,
    input  logic [31:0]              write_inst1,
    input  logic [31:0]              write_inst2,
    input  logic [31:0]              write_addr1,
    input  logic [31:0]              write_addr2,
    input  logic                     read_en1,
    input  logic                     read_en2,
    output logic [31:0]              read_inst1,
    output logic [31:0]              read_inst2,
    output logic [31:0]              read_addr1,
    output logic [31:0]              read_addr2,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] addr_mem [DEPTH];

    logic [1:0]    wr_req;
    logic [1:0]    rd_req;
    logic [1:0]    wr_num;
    logic [1:0]    rd_num;
    logic [CW-1:0] free_slots;
    logic          wr_accept;

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    // NOTE: acceptance and pop count both use the pre-edge count, so pops in
    // the same cycle never make room for a write that would otherwise be refused.
    always_comb begin
        wr_req     = write_en1 ? (write_en2 ? 2'd2 : 2'd1) : 2'd0;
        rd_req     = read_en1  ? (read_en2  ? 2'd2 : 2'd1) : 2'd0;
        free_slots = DEPTH_C - count;
        wr_accept  = (wr_req != 2'd0) && (free_slots >= CW'(wr_req));
        wr_num     = wr_accept ? wr_req : 2'd0;
        rd_num     = (CW'(rd_req) > count) ? count[1:0] : rd_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (fifo_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(rd_num);
            tail  <= tail + AW'(wr_num);
            count <= count + CW'(wr_num) - CW'(rd_num);
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read port,
    // so stale words are never visible after reset or flush.
    always_ff @(posedge clk) begin
        if (!fifo_flush && wr_num != 2'd0) begin
            inst_mem[tail] <= write_inst1;
            addr_mem[tail] <= write_addr1;
            if (wr_num == 2'd2) begin
                inst_mem[tail_p1] <= write_inst2;
                addr_mem[tail_p1] <= write_addr2;
            end
        end
    end

    always_comb begin
        read_inst1 = '0;
        read_addr1 = '0;
        read_inst2 = '0;
        read_addr2 = '0;
        if (count >= CW'(1)) begin
            read_inst1 = inst_mem[head];
            read_addr1 = addr_mem[head];
        end
        if (count >= CW'(2)) begin
            read_inst2 = inst_mem[head_p1];
            read_addr2 = addr_mem[head_p1];
        end
    end

    assign empty        = (count == '0);
    assign almost_empty = (count == CW'(1));
    assign almost_full  = (count >= DEPTH_C - CW'(2));
    assign full         = (count == DEPTH_C);

`ifdef INST_FIFO_OVERFLOW_EN
    // Sticky until reset or flush; a flush wins over a same-cycle rejection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fifo_flush) begin
            overflow <= 1'b0;
        end else if (wr_req != 2'd0 && !wr_accept) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fifo.sv
// Randomised and directed bench for instruction_fifo (DEPTH=16) against a queue model.
module tb_instruction_fifo;

    localparam int DEPTH = 16;
`ifdef INST_FIFO_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_flush;
    logic        write_en1, write_en2;
    logic [31:0] write_inst1, write_inst2, write_addr1, write_addr2;
    logic        read_en1, read_en2;
    logic [31:0] read_inst1, read_inst2, read_addr1, read_addr2;
    logic        empty, almost_empty, almost_full, full;
    logic [4:0]  count;
    logic        overflow;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } entry_t;

    entry_t model_q[$];
    bit     model_ovf;
    int     checks;
    int     errors;

    instruction_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_flush   (fifo_flush),
        .write_en1    (write_en1),
        .write_en2    (write_en2),
        .write_inst1  (write_inst1),
        .write_inst2  (write_inst2),
        .write_addr1  (write_addr1),
        .write_addr2  (write_addr2),
        .read_en1     (read_en1),
        .read_en2     (read_en2),
        .read_inst1   (read_inst1),
        .read_inst2   (read_inst2),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .empty        (empty),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".count"},        32'(count),        32'(n));
        check({tag, ".empty"},        32'(empty),        32'(n == 0));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n == 1));
        check({tag, ".almost_full"},  32'(almost_full),  32'(n >= DEPTH - 2));
        check({tag, ".full"},         32'(full),         32'(n == DEPTH));
        check({tag, ".overflow"},     32'(overflow),     32'(model_ovf));
        check({tag, ".read_inst1"},   read_inst1, (n >= 1) ? model_q[0].inst : 32'h0);
        check({tag, ".read_addr1"},   read_addr1, (n >= 1) ? model_q[0].addr : 32'h0);
        check({tag, ".read_inst2"},   read_inst2, (n >= 2) ? model_q[1].inst : 32'h0);
        check({tag, ".read_addr2"},   read_addr2, (n >= 2) ? model_q[1].addr : 32'h0);
    endtask

    // Reference behaviour: a request is all-or-nothing against the space
    // seen at the start of the cycle; pops are clipped to what is stored.
    task automatic model_step(input bit we1, input bit we2, input logic [31:0] i1,
                              input logic [31:0] i2, input logic [31:0] a1,
                              input logic [31:0] a2, input bit re1, input bit re2,
                              input bit fl);
        int nw, nr, pre;
        entry_t e;
        nw  = we1 ? (we2 ? 2 : 1) : 0;
        nr  = re1 ? (re2 ? 2 : 1) : 0;
        pre = model_q.size();
        if (fl) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            for (int k = 0; k < nr && k < pre; k++) void'(model_q.pop_front());
            if (nw > 0 && (DEPTH - pre) >= nw) begin
                e.inst = i1; e.addr = a1; model_q.push_back(e);
                if (nw == 2) begin
                    e.inst = i2; e.addr = a2; model_q.push_back(e);
                end
            end else if (nw > 0 && OVF_EN) begin
                model_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input string tag, input bit we1, input bit we2,
                        input logic [31:0] i1, input logic [31:0] i2,
                        input logic [31:0] a1, input logic [31:0] a2,
                        input bit re1, input bit re2, input bit fl);
        write_en1 = we1; write_en2 = we2;
        write_inst1 = i1; write_inst2 = i2;
        write_addr1 = a1; write_addr2 = a2;
        read_en1 = re1; read_en2 = re2;
        fifo_flush = fl;
        @(posedge clk);
        model_step(we1, we2, i1, i2, a1, a2, re1, re2, fl);
        #1;
        check_all(tag);
    endtask

    task automatic push1(input string tag);
        step(tag, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_to(input int target);
        while (model_q.size() < target) push1("fill");
    endtask

    task automatic flush_all();
        step("flush", 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int rd_idx;
        checks = 0;
        errors = 0;
        model_ovf = 1'b0;
        rst = 1'b1;
        fifo_flush = 1'b0;
        write_en1 = 1'b0; write_en2 = 1'b0;
        write_inst1 = '0; write_inst2 = '0; write_addr1 = '0; write_addr2 = '0;
        read_en1 = 1'b0; read_en2 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Paired push, visible the following cycle.
        step("pair", 1'b1, 1'b1, 32'h24020001, 32'h24030002,
             32'hBFC00000, 32'hBFC00004, 1'b0, 1'b0, 1'b0);
        check("pair_inst1", read_inst1, 32'h24020001);
        check("pair_inst2", read_inst2, 32'h24030002);
        check("pair_addr2", read_addr2, 32'hBFC00004);
        check("pair_count", 32'(count), 32'd2);

        // Dual pop with only one entry stored.
        step("pop1", 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        check("one_left_inst2", read_inst2, 32'h0);
        step("pop_clip", 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        check("pop_clip_empty", 32'(empty), 32'd1);
        step("pop_on_empty", 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);

        // Dual write at count=15 refused while the dual read still pops.
        fill_to(15);
        step("rej_dual", 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
        check("rej_count", 32'(count), 32'd13);
        check("rej_overflow", 32'(overflow), 32'(OVF_EN));
        step("slot2_alone", 1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
        fill_to(16);
        check("full_flag", 32'(full), 32'd1);
        flush_all();

        // Single pushes interleaved with pops; PCs must come back in order.
        rd_idx = 0;
        for (int i = 0; i < 40; i++) begin
            bit pop;
            pop = (i % 4) != 0;
            if (pop && model_q.size() > 0) begin
                check("order_pc", read_addr1, 32'h8000_0000 + 32'(rd_idx * 4));
                rd_idx++;
            end
            step("wrap", 1'b1, 1'b0, $urandom, 0, 32'h8000_0000 + 32'(i * 4), 0,
                 pop, 1'b0, 1'b0);
        end
        while (model_q.size() > 0) begin
            check("drain_pc", read_addr1, 32'h8000_0000 + 32'(rd_idx * 4));
            rd_idx++;
            step("drain", 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        end
        check("drain_total", 32'(rd_idx), 32'd40);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom % 4) != 0, $urandom % 2, $urandom, $urandom,
                 $urandom, $urandom, ($urandom % 3) == 0, $urandom % 2,
                 ($urandom % 60) == 0);
        end

        // Flush with a same-cycle write after overflow was set.
        flush_all();
        fill_to(16);
        push1("rej_full");
        while (model_q.size() > 9)
            step("pop_to_9", 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        step("flush_wr", 1'b1, 1'b0, $urandom, 0, $urandom, 0, 1'b0, 1'b0, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset mid-cycle at count=7.
        fill_to(7);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        check_all("async_rst");
        check("async_rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
